cnu_serial: RTL and testbench

//  Serial min-sum check node unit for the layered LDPC decoder. Accepts one

---
 rtl/cnu_pkg.sv | 28 ++
 rtl/cnu_scale_sat.sv | 37 +++
 rtl/cnu_serial.sv | 220 ++++++++++++++++++++++
 tb/tb_cnu_serial.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// ============================================================================
// Module   : cnu_pkg
// Purpose  : Shared constants, width helpers and FSM encodings for the serial
//            min-sum check node unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnu_pkg;

    localparam int D_MAX_DEF  = 6;
    localparam int RES_W_DEF  = 6;
    localparam int EXT_W_DEF  = 3;
    localparam int IDX_W_DEF  = 3;
    localparam int DATA_W_DEF = RES_W_DEF + EXT_W_DEF;
    localparam int MAG_MAX    = 2**(DATA_W_DEF-1) - 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    function automatic int data_w(input int res_w, input int ext_w);
        return res_w + ext_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnu_scale_sat.sv
// ============================================================================
// Module   : cnu_scale_sat
// Purpose  : Combinational magnitude scaling: x3/4 normalization or offset
//            subtraction, saturated to RES_W-1 magnitude bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnu_scale_sat #(
    parameter int MAG_W = 8,
    parameter int RES_W = 6
) (
    input  logic [MAG_W-1:0] m,
    input  logic             mode,
    input  logic [RES_W-2:0] offset,
    output logic [RES_W-2:0] s
);

    localparam logic [RES_W-2:0] C_S_MAX = '1;

    logic [MAG_W-1:0] w_norm;
    logic [RES_W-2:0] w_s_norm;
    logic [RES_W-2:0] w_sat_lo;
    logic [RES_W-2:0] w_s_off;

    always_comb begin
        // 3*m needs two extra bits before the divide-by-four
        w_norm   = MAG_W'(({2'b00, m} + {1'b0, m, 1'b0}) >> 2);
        w_s_norm = (w_norm > MAG_W'(C_S_MAX)) ? C_S_MAX : w_norm[RES_W-2:0];
        w_sat_lo = (m > MAG_W'(C_S_MAX)) ? C_S_MAX : m[RES_W-2:0];
        w_s_off  = (w_sat_lo > offset) ? (w_sat_lo - offset) : '0;
        s        = mode ? w_s_off : w_s_norm;
    end

endmodule

`default_nettype wire

// File: rtl/cnu_serial.sv
// ============================================================================
// Module   : cnu_serial
// Purpose  : Serial min-sum check node unit; collects one q per beat, then
//            emits one r per beat. Optional offset mode via CNU_OFFSET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnu_serial
    import cnu_pkg::*;
#(
    parameter int D_MAX = D_MAX_DEF,
    parameter int RES_W = RES_W_DEF,
    parameter int EXT_W = EXT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [IDX_W-1:0]       deg,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RES_W+EXT_W-1:0] in_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       out_r,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   deg_err
`ifdef CNU_OFFSET_EN
    ,
    input  logic                   mode,
    input  logic [RES_W-2:0]       offset
`endif
);

    localparam int DATA_W = data_w(RES_W, EXT_W);
    localparam int MAG_W  = DATA_W - 1;
    localparam logic [MAG_W-1:0] C_MAG_MAX = '1;
    localparam logic [IDX_W-1:0] C_DEG_MAX = IDX_W'(D_MAX);
    localparam logic [IDX_W-1:0] C_DEG_MIN = IDX_W'(2);
    localparam logic [IDX_W-1:0] C_ONE     = IDX_W'(1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_deg, r_cnt, r_ocnt, r_idx;
    logic [MAG_W-1:0] r_min1, r_min2;
    logic [D_MAX-1:0] r_sgn;
    logic             r_par;
    logic             r_deg_err;

    logic             w_idle, w_emit, w_accept, w_take;
    logic             w_deg_bad;
    logic [IDX_W-1:0] w_deg_eff, w_deg_last, w_bidx;
    logic [DATA_W-1:0] w_neg_q;
    logic [MAG_W-1:0] w_mag, w_base1, w_base2;
    logic [MAG_W-1:0] w_min1_nx, w_min2_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [D_MAX-1:0] w_sgn_nx;
    logic             w_par_nx;
    logic             w_sgn_sel;
    logic             w_mode_cur;
    logic [RES_W-2:0] w_off_cur;
    logic [RES_W-2:0] w_s1, w_s2, w_s;
    logic [RES_W-1:0] w_r_mag;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_emit     = (r_state == ST_EMIT);
    assign in_ready   = ~rst & (w_idle | (r_state == ST_COLLECT));
    assign out_valid  = w_emit;
    assign w_accept   = en & in_valid & in_ready;
    assign w_take     = en & w_emit & out_ready;
    assign w_deg_bad  = (deg < C_DEG_MIN) || (deg > C_DEG_MAX);
    assign w_deg_eff  = w_deg_bad ? C_DEG_MAX : deg;
    assign w_deg_last = r_deg - C_ONE;
    assign w_bidx     = w_idle ? '0 : r_cnt;

    // Most negative q has no positive twin and clips to the largest magnitude
    always_comb begin
        w_neg_q = (~in_q) + DATA_W'(1);
        if (in_q[DATA_W-1])
            w_mag = w_neg_q[DATA_W-1] ? C_MAG_MAX : w_neg_q[MAG_W-1:0];
        else
            w_mag = in_q[MAG_W-1:0];
    end

    always_comb begin
        w_base1   = w_idle ? C_MAG_MAX : r_min1;
        w_base2   = w_idle ? C_MAG_MAX : r_min2;
        w_min1_nx = w_base1;
        w_min2_nx = w_base2;
        w_idx_nx  = w_idle ? '0 : r_idx;
        if (w_mag < w_base1) begin
            w_min2_nx = w_base1;
            w_min1_nx = w_mag;
            w_idx_nx  = w_bidx;
        end else if (w_mag < w_base2) begin
            w_min2_nx = w_mag;
        end
    end

    // Beat 0 clears stale sign bits so a shorter row never sees old signs
    always_comb begin
        w_sgn_nx = w_idle ? '0 : r_sgn;
        for (int k = 0; k < D_MAX; k++) begin
            if (IDX_W'(k) == w_bidx)
                w_sgn_nx[k] = in_q[DATA_W-1];
        end
        w_par_nx = (w_idle ? 1'b0 : r_par) ^ in_q[DATA_W-1];
    end

    always_comb begin
        w_sgn_sel = 1'b0;
        for (int k = 0; k < D_MAX; k++) begin
            if (IDX_W'(k) == r_ocnt)
                w_sgn_sel = r_sgn[k];
        end
    end

`ifdef CNU_OFFSET_EN
    logic             r_mode;
    logic [RES_W-2:0] r_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_offset <= '0;
        end else if (en && w_idle && w_accept) begin
            r_mode   <= mode;
            r_offset <= offset;
        end
    end

    assign w_mode_cur = r_mode;
    assign w_off_cur  = r_offset;
`else
    assign w_mode_cur = 1'b0;
    assign w_off_cur  = '0;
`endif

    cnu_scale_sat #(.MAG_W(MAG_W), .RES_W(RES_W)) u_scale_min1 (
        .m      (r_min1),
        .mode   (w_mode_cur),
        .offset (w_off_cur),
        .s      (w_s1)
    );

    cnu_scale_sat #(.MAG_W(MAG_W), .RES_W(RES_W)) u_scale_min2 (
        .m      (r_min2),
        .mode   (w_mode_cur),
        .offset (w_off_cur),
        .s      (w_s2)
    );

    assign w_s      = (r_ocnt == r_idx) ? w_s2 : w_s1;
    assign w_r_mag  = {1'b0, w_s};
    assign out_r    = !w_emit ? '0 :
                      ((r_par ^ w_sgn_sel) ? (RES_W'(0) - w_r_mag) : w_r_mag);
    assign out_idx  = w_emit ? r_ocnt : '0;
    assign out_last = w_emit & (r_ocnt == w_deg_last);
    assign deg_err  = r_deg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_deg     <= C_DEG_MAX;
            r_cnt     <= '0;
            r_ocnt    <= '0;
            r_idx     <= '0;
            r_min1    <= C_MAG_MAX;
            r_min2    <= C_MAG_MAX;
            r_sgn     <= '0;
            r_par     <= 1'b0;
            r_deg_err <= 1'b0;
        end else if (en) begin
            r_deg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_deg     <= w_deg_eff;
                        r_deg_err <= w_deg_bad;
                        r_cnt     <= C_ONE;
                        r_ocnt    <= '0;
                        r_state   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (r_cnt == w_deg_last) begin
                            r_state <= ST_EMIT;
                            r_ocnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_take) begin
                        if (r_ocnt == w_deg_last) begin
                            r_state <= ST_IDLE;
                            r_ocnt  <= '0;
                        end else begin
                            r_ocnt <= r_ocnt + C_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_min1 <= w_min1_nx;
                r_min2 <= w_min2_nx;
                r_idx  <= w_idx_nx;
                r_sgn  <= w_sgn_nx;
                r_par  <= w_par_nx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnu_serial.sv
// ============================================================================
// Module   : tb_cnu_serial
// Purpose  : Directed self-checking bench for cnu_serial (CNU_OFFSET_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cnu_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] deg = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_q = 9'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_r;
    logic [2:0] out_idx;
    logic       out_last;
    logic       deg_err;
`ifdef CNU_OFFSET_EN
    logic       mode = 1'b0;
    logic [4:0] offset = 5'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int q_vec [6];
    int r_exp [6];

    always #5 clk = ~clk;

    cnu_serial u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .deg       (deg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .deg_err   (deg_err)
`ifdef CNU_OFFSET_EN
        ,
        .mode      (mode),
        .offset    (offset)
`endif
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives n beats of q_vec; optional 2-cycle en=0 gap before beat gap_at
    task automatic send_row(input int d, input int n, input int gap_at, input int de);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                in_valid = 1'b0;
                en       = 1'b0;
                @(negedge clk);
                @(negedge clk);
                en = 1'b1;
            end
            deg      = 3'(d);
            in_q     = 9'(q_vec[i]);
            in_valid = 1'b1;
            chk("in_ready_collect", in_ready, 1);
            if (i == 1) chk("deg_err_pulse", deg_err, de);
            if (i == 2) chk("deg_err_clear", deg_err, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects r_exp; optional 3-cycle out_ready stall at beat stall_at
    task automatic recv_row(input int n, input int stall_at);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) chk("in_ready_emit", in_ready, 0);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_r", $signed(out_r), r_exp[k]);
                    chk("stall_idx", out_idx, k);
                end
                out_ready = 1'b1;
            end
            chk("out_valid", out_valid, 1);
            chk("out_r", $signed(out_r), r_exp[k]);
            chk("out_idx", out_idx, k);
            chk("out_last", out_last, (k == n - 1) ? 1 : 0);
        end
        @(negedge clk);
        chk("row_done_valid", out_valid, 0);
        chk("row_done_ready", in_ready, 1);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", $signed(out_r), 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_deg_err", deg_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // Test 1: min2 on idx 4
        q_vec = '{10, -4, 20, -7, 3, 50};
        r_exp = '{2, -2, 2, -2, 3, 2};
        send_row(6, 6, -1, 0);
        recv_row(6, -1);

        // Test 2: tie lands in min2, idx stays 0
        q_vec = '{5, 5, 9, 9, 9, 9};
        r_exp = '{3, 3, 3, 3, 3, 3};
        send_row(6, 6, -1, 0);
        recv_row(6, -1);

        // Test 3: most-negative input and output saturation
        q_vec = '{-256, 100, 120, 200, 0, 0};
        r_exp = '{31, -31, -31, -31, 0, 0};
        send_row(4, 4, -1, 0);
        recv_row(4, -1);

        // Test 4: backpressure mid-emit
        q_vec = '{10, -4, 20, -7, 3, 50};
        r_exp = '{2, -2, 2, -2, 3, 2};
        send_row(6, 6, -1, 0);
        recv_row(6, 2);

        // Test 5: out-of-range degrees clamp to 6; en gap mid-collect
        send_row(1, 6, -1, 1);
        recv_row(6, -1);
        send_row(7, 6, -1, 1);
        recv_row(6, -1);
        send_row(6, 6, 3, 0);
        recv_row(6, -1);

        // Test 6: reset mid-collect drops the row
        send_row(6, 3, -1, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        q_vec = '{8, 8, -8, 0, 0, 0};
        r_exp = '{-6, -6, 6, 0, 0, 0};
        send_row(3, 3, -1, 0);
        recv_row(3, -1);

        // Reset while emitting clears outputs asynchronously
        q_vec = '{10, -4, 20, -7, 3, 50};
        send_row(6, 6, -1, 0);
        chk("emit_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_emit_valid", out_valid, 0);
        chk("rst_emit_r", $signed(out_r), 0);
        @(negedge clk);
        rst = 1'b0;
        q_vec = '{5, 5, 9, 9, 9, 9};
        r_exp = '{3, 3, 3, 3, 3, 3};
        send_row(6, 6, -1, 0);
        recv_row(6, -1);

`ifdef CNU_OFFSET_EN
        // Offset mode: sat(3)-1=2, sat(4)-1=3
        mode   = 1'b1;
        offset = 5'd1;
        q_vec = '{10, -4, 20, -7, 3, 50};
        r_exp = '{2, -2, 2, -2, 3, 2};
        send_row(6, 6, -1, 0);
        recv_row(6, -1);
        // Offset mode: sat(100)=31 -> 30
        q_vec = '{-256, 100, 120, 200, 0, 0};
        r_exp = '{30, -30, -30, -30, 0, 0};
        send_row(4, 4, -1, 0);
        recv_row(4, -1);
        mode   = 1'b0;
        offset = 5'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
